// File: rtl/r200_dmem_resp.sv
// r200_dmem_resp: data-memory responder for the r200 MEM stage.
//   A word-organised little-endian RAM behind a valid/ready request channel.
//   Each accepted request produces exactly one rsp_valid pulse, WAIT_CYC+1
//   cycles after the accept edge.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while IDLE)
//   req_we                1 = store, 0 = load
//   req_addr              byte address (word = [31:2], lane = [1:0])
//   req_wdata             right-aligned store data
//   req_func3             RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   rsp_valid             one-cycle response strobe
//   rsp_rdata             extended load data (0 for stores and errors)
//   rsp_err               misaligned / illegal / out-of-range access
module r200_dmem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYC    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        l_we;
  logic [31:0] l_addr, l_wdata;
  logic [2:0]  l_func3;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, commit;
  logic        c_we;
  logic [31:0] c_addr, c_wdata;
  logic [2:0]  c_func3;
  logic        c_err, bad;
  logic [1:0]  lane;
  logic [AW-1:0] widx;
  logic [31:0] rd_word, ld_data, wbus;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [3:0]  be;

  // Gated by rst_n so the requester never sees ready while reset is held.
  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;

  // With no wait states the commit happens on the accept edge itself, so
  // the live request fields are used instead of the latched copy.
  always_comb begin
    if (WAIT_CYC == 0) begin
      commit  = accept;
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_func3 = req_func3;
    end else begin
      commit  = (state == WAIT) && (cnt == 3'd1);
      c_we    = l_we;
      c_addr  = l_addr;
      c_wdata = l_wdata;
      c_func3 = l_func3;
    end
  end

  assign lane = c_addr[1:0];
  assign widx = c_addr[AW+1:2];

  // Access checking: alignment, legal funct3, load-only unsigned forms.
  always_comb begin
    case (c_func3)
      3'b000:  bad = 1'b0;
      3'b100:  bad = c_we;
      3'b001:  bad = c_addr[0];
      3'b101:  bad = c_we | c_addr[0];
      3'b010:  bad = (c_addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    c_err = bad || (c_addr[31:2] >= DEPTH_W);
  end

  // Load path. An out-of-range index may alias a real word; the error
  // flag forces the returned data to zero in that case.
  assign rd_word = mem[widx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = c_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (c_func3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_data = {24'b0, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_data = {16'b0, rd_half};
      3'b010:  ld_data = rd_word;
      default: ld_data = 32'b0;
    endcase
  end

  // Store path: replicate right-aligned data across lanes, enable by size.
  always_comb begin
    case (c_func3[1:0])
      2'b00: begin
        be   = 4'b0001 << lane;
        wbus = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        be   = c_addr[1] ? 4'b1100 : 4'b0011;
        wbus = {2{c_wdata[15:0]}};
      end
      2'b10: begin
        be   = 4'b1111;
        wbus = c_wdata;
      end
      default: begin
        be   = 4'b0000;
        wbus = c_wdata;
      end
    endcase
  end

  // RAM is not reset; commit is already suppressed while rst_n is low
  // because the FSM is held in IDLE.
  always_ff @(posedge clk) begin
    if (commit && c_we && !c_err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wbus[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'b0;
      rsp_err   <= 1'b0;
      l_we      <= 1'b0;
      l_addr    <= 32'b0;
      l_wdata   <= 32'b0;
      l_func3   <= 3'b0;
    end else begin
      rsp_valid <= commit;
      if (commit) begin
        rsp_rdata <= (c_err || c_we) ? 32'b0 : ld_data;
        rsp_err   <= c_err;
      end
      case (state)
        IDLE: if (accept) begin
          l_we    <= req_we;
          l_addr  <= req_addr;
          l_wdata <= req_wdata;
          l_func3 <= req_func3;
          cnt     <= 3'(WAIT_CYC);
          state   <= (WAIT_CYC == 0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r200_dmem_resp.sv
// Directed bench for r200_dmem_resp (WAIT_CYC=1, DEPTH_WORDS=64).
module tb_r200_dmem_resp;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_func3 = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  r200_dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_func3(req_func3),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One transaction: handshake, check 1-wait-state latency and 1-cycle pulse.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] rdata, output logic err);
    int t;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_func3 = f3;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) chk({tag, " ready_timeout"}, 32'(t), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    t = 0;
    do begin
      @(posedge clk);
      #1 t++;
    end while (!rsp_valid && t < 10);
    chk({tag, " latency"}, 32'(t), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk);
    #1 chk({tag, " pulse_width"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          acc_n, pulse_n, rdy_n, last_acc;
  logic [31:0] last_rd;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", {31'b0, req_ready}, 32'd0);
    chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("idle ready", {31'b0, req_ready}, 32'd1);

    // 1: SW / LW
    do_req("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er);
    chk("sw10 err", {31'b0, er}, 32'd0);
    chk("sw10 rdata", rd, 32'd0);
    do_req("lw10", 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    chk("lw10 rdata", rd, 32'hDEADBEEF);
    chk("lw10 err", {31'b0, er}, 32'd0);

    // 2: byte store and byte loads
    do_req("sb11", 1'b1, 32'h11, 32'h000000A5, 3'b000, rd, er);
    do_req("lw10b", 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    chk("lw10 after sb", rd, 32'hDEADA5EF);
    do_req("lb11", 1'b0, 32'h11, 32'h0, 3'b000, rd, er);
    chk("lb11", rd, 32'hFFFFFFA5);
    do_req("lbu11", 1'b0, 32'h11, 32'h0, 3'b100, rd, er);
    chk("lbu11", rd, 32'h000000A5);

    // 3: halfword store and loads
    do_req("sh12", 1'b1, 32'h12, 32'h00008001, 3'b001, rd, er);
    do_req("lh12", 1'b0, 32'h12, 32'h0, 3'b001, rd, er);
    chk("lh12", rd, 32'hFFFF8001);
    do_req("lhu12", 1'b0, 32'h12, 32'h0, 3'b101, rd, er);
    chk("lhu12", rd, 32'h00008001);
    do_req("lw10c", 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    chk("lw10 after sh", rd, 32'h8001A5EF);

    // 4: error cases
    do_req("lw12", 1'b0, 32'h12, 32'h0, 3'b010, rd, er);
    chk("lw12 misalign err", {31'b0, er}, 32'd1);
    chk("lw12 misalign rdata", rd, 32'd0);
    do_req("sh13", 1'b1, 32'h13, 32'h0000FFFF, 3'b001, rd, er);
    chk("sh13 misalign err", {31'b0, er}, 32'd1);
    do_req("lw10d", 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    chk("lw10 after bad sh", rd, 32'h8001A5EF);
    do_req("f3_011", 1'b0, 32'h10, 32'h0, 3'b011, rd, er);
    chk("func3 011 err", {31'b0, er}, 32'd1);
    do_req("oor", 1'b0, 32'(4 * DEPTH), 32'h0, 3'b010, rd, er);
    chk("oor err", {31'b0, er}, 32'd1);
    chk("oor rdata", rd, 32'd0);
    do_req("sbu", 1'b1, 32'h10, 32'hFF, 3'b100, rd, er);
    chk("store func3 100 err", {31'b0, er}, 32'd1);
    do_req("lw10e", 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    chk("lw10 after bad sbu", rd, 32'h8001A5EF);

    // 5: req_valid held high across 4 back-to-back LWs
    acc_n = 0; pulse_n = 0; rdy_n = 0; last_acc = -1; last_rd = '0;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; req_func3 = 3'b010; req_valid = 1'b1;
    for (int n = 0; n < 14; n++) begin
      if (n > 0) @(negedge clk);
      if (acc_n == 4) req_valid = 1'b0;
      if (req_ready && n <= 9) rdy_n++;
      if (rsp_valid) begin
        pulse_n++;
        last_rd = rsp_rdata;
      end
      if (req_valid && req_ready) begin
        if (last_acc >= 0) chk("b2b accept spacing", 32'(n - last_acc), 32'd3);
        last_acc = n;
        acc_n++;
      end
    end
    req_valid = 1'b0;
    chk("b2b accepts", 32'(acc_n), 32'd4);
    chk("b2b pulses", 32'(pulse_n), 32'd4);
    chk("b2b ready cycles", 32'(rdy_n), 32'd4);
    chk("b2b rdata", last_rd, 32'h8001A5EF);

    // 6: reset during WAIT discards the store
    do_req("sw20z", 1'b1, 32'h20, 32'h0, 3'b010, rd, er);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_func3 = 3'b010;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("in WAIT ready", {31'b0, req_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("midrst ready", {31'b0, req_ready}, 32'd0);
    pulse_n = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1 if (rsp_valid) pulse_n++;
    end
    chk("midrst ready held", {31'b0, req_ready}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1 if (rsp_valid) pulse_n++;
    end
    chk("midrst no pulse", 32'(pulse_n), 32'd0);
    do_req("lw20", 1'b0, 32'h20, 32'h0, 3'b010, rd, er);
    chk("lw20 after rst", rd, 32'h00000000);
    chk("lw20 err", {31'b0, er}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/r200_dmem_resp.md
Name: r200_dmem_resp

Overview:
Data-memory responder for the r200 pipeline. It serves the MEM-stage load/store initiator over a valid/ready request channel and a one-cycle response pulse. It holds a word-organised little-endian RAM, decodes RV32I func3 into byte lanes, and sign- or zero-extends loads. Misaligned, illegal-func3 and out-of-range accesses are flagged, and no write is performed for them.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM
WAIT_CYC, 1, wait states inserted between request accept and response (legal range 0..7)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
req_func3  in  3  RV32I funct3 of the load/store
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  32  extended load data; 0 for stores and for errors
rsp_err  out  1  access error, qualified by rsp_valid

Behaviour:
- Reset is asynchronous and active-low: clk, rst_n.
- Reset values:
  - state = IDLE, wait counter = 0
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
  - req_ready = 0 while rst_n is low; RAM contents are not reset.
- FSM: IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: req_ready = 1. On req_valid && req_ready, latch we/addr/wdata/func3. Go to WAIT with counter = WAIT_CYC, or straight to RESP if WAIT_CYC = 0.
  - WAIT: req_ready = 0. Decrement the counter; go to RESP at the edge where the counter reaches 0.
  - RESP: req_ready = 0, rsp_valid = 1 for exactly one cycle, then IDLE.
- Commit: the RAM write and the read-data capture occur at the edge that enters RESP. rsp_rdata and rsp_err are registered at that same edge.
- Latency: accept at edge N -> rsp_valid high in the cycle after edge N+WAIT_CYC.
  - Next accept is possible at edge N+WAIT_CYC+2.
  - Sustained throughput is one request per WAIT_CYC+2 cycles.
- Requester rules:
  - Must hold the request fields stable while req_valid && !req_ready.
  - May drop req_valid without a handshake; nothing is accepted in that case.
  - There is no response backpressure; the requester must consume rsp_valid.
- Word index = req_addr[31:2]; byte lane = req_addr[1:0]; little-endian.
- Loads:
  - LB (000) sign-extends the selected byte; LBU (100) zero-extends it.
  - LH (001) sign-extends the selected halfword (lane 0 or 2); LHU (101) zero-extends it.
  - LW (010) returns the word.
- Stores:
  - SB (000) writes 1 byte lane; SH (001) writes 2 lanes; SW (010) writes 4 lanes.
  - Unwritten lanes are preserved.
- Error (rsp_err = 1, rsp_rdata = 0, RAM unchanged) when any of the following holds:
  - word index >= DEPTH_WORDS;
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - func3 in {011, 110, 111};
  - a store with func3 in {100, 101}.
- rsp_rdata and rsp_err hold their values outside rsp_valid; they are only meaningful while rsp_valid = 1.
- Reset mid-transaction:
  - If reset is asserted before the commit edge, the in-flight request is discarded, no write occurs, and rsp_valid stays 0.
  - If reset is asserted during RESP, rsp_valid drops immediately; the write has already committed.
- Requests presented while not in IDLE are not accepted and have no effect.

Test Plan:
1. WAIT_CYC=1: SW 0x10 <- 0xDEADBEEF accepted at edge N -> rsp_valid=1 after edge N+1, err=0. Then LW 0x10 -> rsp_rdata=0xDEADBEEF, err=0.
2. SB 0x11 <- 0x000000A5 -> LW 0x10 = 0xDEADA5EF. LB 0x11 = 0xFFFFFFA5; LBU 0x11 = 0x000000A5.
3. SH 0x12 <- 0x00008001 -> LH 0x12 = 0xFFFF8001; LHU 0x12 = 0x00008001; LW 0x10 = 0x8001A5EF.
4. LW 0x12 -> err=1, rdata=0. SH 0x13 <- 0xFFFF -> err=1, and a following LW 0x10 still returns 0x8001A5EF. func3=011 -> err=1. Address 4*DEPTH_WORDS -> err=1.
5. req_valid held high continuously with 4 LW requests (WAIT_CYC=1) -> accepts exactly every 3 cycles, 4 rsp_valid pulses, req_ready low outside IDLE.
6. Word 0x20 = 0. Start SW 0x20 <- 0x12345678 and pull rst_n low during WAIT -> rsp_valid never rises and req_ready=0 during reset. After release, LW 0x20 returns 0x00000000.
